// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter (8E1 when UART_TX_BUF_PARITY_EN is defined) with a 2**DEPTH_LOG2-byte FIFO.
// Latency: a byte pushed into an idle, empty block drives the start bit one cycle after the push edge.
// Backpressure: none; a write while full is dropped and sets sticky overflow, unless a pop happens on the same edge.
module uart_tx_buf #(
    parameter int BAUD_DIV   = 868,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_we,
    input  logic [7:0]            wr_data,
    output logic                  uart_tx,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  busy
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

`ifdef UART_TX_BUF_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state;
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [7:0]            mem [DEPTH];
    logic [7:0]            shreg;
    logic [15:0]           baud_cnt;
    logic [2:0]            bit_idx;
    logic                  bit_end;
    logic                  pop;
    logic                  push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign bit_end = (baud_cnt == 16'd0);
    assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign push    = uart_we && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (uart_we && !push)
                overflow <= 1'b1;
        end
    end

    // When full with a simultaneous pop, write and read hit the same slot; the pop sees the old byte.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                        state    <= START;
                        uart_tx  <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= BAUD_LAST;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        uart_tx  <= shreg[0];
                        bit_idx  <= 3'd0;
                        baud_cnt <= BAUD_LAST;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_LAST;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_BUF_PARITY_EN
                            state   <= PARITY;
                            uart_tx <= ^shreg;
`else
                            state   <= STOP;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_BUF_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        uart_tx  <= 1'b1;
                        baud_cnt <= BAUD_LAST;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        // Chain straight into the next frame so back-to-back bytes have no idle gap.
                        if (pop) begin
                            shreg    <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                            state    <= START;
                            uart_tx  <= 1'b0;
                            baud_cnt <= BAUD_LAST;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Randomized and directed bench for uart_tx_buf against a frame-level reference model.
module tb_uart_tx_buf;

    localparam int BAUD_DIV   = 4;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef UART_TX_BUF_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC  = FRAME_BITS * BAUD_DIV;

    logic                clk;
    logic                rst_n;
    logic                uart_we;
    logic [7:0]          wr_data;
    logic                uart_tx;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                busy;

    int tests_run;
    int tests_failed;
    int busy_cycles;

    // Reference model: byte queue plus the frame in flight as a cycle offset.
    logic [7:0] q[$];
    bit         active;
    int         pos;
    logic [7:0] cur;
    bit         ovf;

    uart_tx_buf #(.BAUD_DIV(BAUD_DIV), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .uart_we(uart_we), .wr_data(wr_data),
        .uart_tx(uart_tx), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (!active) return 1'b1;
        b = pos / BAUD_DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
`ifdef UART_TX_BUF_PARITY_EN
        if (b == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    function automatic void model_reset();
        q.delete();
        active = 0;
        pos    = 0;
        cur    = 8'h00;
        ovf    = 0;
    endfunction

    function automatic void model_step(input bit we, input logic [7:0] d);
        bit last, pop, acc;
        last = active && (pos == FRAME_CYC - 1);
        pop  = (q.size() > 0) && (!active || last);
        acc  = we && ((q.size() < DEPTH) || pop);
        if (we && !acc) ovf = 1;
        if (pop) begin
            cur    = q.pop_front();
            active = 1;
            pos    = 0;
        end else if (active) begin
            if (last) active = 0;
            else pos++;
        end
        if (acc) q.push_back(d);
    endfunction

    task automatic check_all();
        if (busy === 1'b1) busy_cycles++;
        check_eq("uart_tx",  uart_tx,  exp_tx());
        check_eq("busy",     busy,     active);
        check_eq("count",    count,    q.size());
        check_eq("empty",    empty,    q.size() == 0);
        check_eq("full",     full,     q.size() == DEPTH);
        check_eq("overflow", overflow, ovf);
    endtask

    // Called at a negedge; inputs are held across the next posedge.
    task automatic step(input bit we, input logic [7:0] d);
        uart_we = we;
        wr_data = d;
        @(posedge clk);
        model_step(we, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    initial begin
        bit ok;
        tests_run    = 0;
        tests_failed = 0;
        busy_cycles  = 0;
        rst_n   = 1'b0;
        uart_we = 1'b0;
        wr_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Single byte into an idle block.
        busy_cycles = 0;
        step(1'b1, 8'h55);
        idle(FRAME_CYC + 10);
        check_eq("single_busy_cycles", busy_cycles, FRAME_CYC);

        // Back-to-back frames.
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        idle(2 * FRAME_CYC + 10);

        // Overflow: sixth consecutive write is dropped.
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_full", full, 1);
        idle(6 * FRAME_CYC);

        // Full FIFO with a push on the STOP-to-START pop edge.
        step(1'b1, 8'h11);
        for (int i = 0; i < 8 && q.size() < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)));
        ok = 0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            if (active && pos == FRAME_CYC - 1 && q.size() == DEPTH) begin
                ok = 1;
                break;
            end
            step(1'b0, 8'h00);
        end
        check_eq("wait_stop_edge", ok, 1);
        step(1'b1, 8'h77);
        check_eq("full_pop_count", count, DEPTH);
        idle((DEPTH + 1) * FRAME_CYC + 10);
        check_eq("drained_empty", empty, 1);

        // Reset mid-frame during data bit 3 of 0xFF.
        step(1'b1, 8'hFF);
        ok = 0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            if (active && pos / BAUD_DIV == 4) begin
                ok = 1;
                break;
            end
            step(1'b0, 8'h00);
        end
        check_eq("wait_data_bit3", ok, 1);
        check_eq("pre_reset_tx", uart_tx, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_tx",    uart_tx, 1);
        check_eq("rst_count", count,   0);
        check_eq("rst_busy",  busy,    0);
        check_eq("rst_empty", empty,   1);
        @(negedge clk);
        rst_n = 1'b1;
        busy_cycles = 0;
        idle(FRAME_CYC + 10);
        check_eq("post_reset_no_frame", busy_cycles, 0);

        // Random traffic: light load, then heavy load.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 1) == 0), 8'($urandom_range(0, 255)));
        idle((DEPTH + 1) * FRAME_CYC + 10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
